// File: rtl/jtcps2_pkg.sv
// Shared CPS2 definitions: key record size, field offsets inside the permuted key,
// and the 8-bit wrap-around add used by the configuration loader checksum.
package jtcps2_pkg;

  localparam int CPS2_KEY_BYTES = 20;

  // Field positions after the CPS2 key bit permutation (applied outside the loader)
  localparam int KEY_LSB      = 0;
  localparam int KEY_MSB      = 63;
  localparam int ADDR_RNG_LSB = 144;
  localparam int ADDR_RNG_MSB = 159;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/jtcps2_cfgload_if.sv
// Download-side and result-side signals of the configuration loader.
// master = download source / consumer, slave = the loader itself.
interface jtcps2_cfgload_if #(
  parameter int BYTES = 20,
  parameter int CW    = $clog2(BYTES + 2)
);
  logic                 restart;
  logic [7:0]           din;
  logic                 din_we;
  logic [8*BYTES-1:0]   cfg;
  logic                 valid;
  logic                 busy;
  logic                 err;
  logic                 ovf;
  logic [CW-1:0]        cnt;

  modport master (output restart, din, din_we,
                  input  cfg, valid, busy, err, ovf, cnt);
  modport slave  (input  restart, din, din_we,
                  output cfg, valid, busy, err, ovf, cnt);
endinterface

// File: rtl/jtcps2_cfgload_acc.sv
// Record accumulator: shadow shift register, running 8-bit sum and a byte
// counter that saturates at the record length. Restart has priority and a
// coincident byte becomes byte 0 of the fresh record.
module jtcps2_cfgload_acc
  import jtcps2_pkg::*;
#(
  parameter  int BYTES = CPS2_KEY_BYTES,
  parameter  int CSUM  = 1,
  localparam int CW    = $clog2(BYTES + 2)
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_restart,
  input  logic                 i_edge,
  input  logic [7:0]           i_din,
  output logic [8*BYTES-1:0]   o_shadow,
  output logic [7:0]           o_sum,
  output logic [CW-1:0]        o_cnt,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_extra
);

  localparam logic [CW-1:0] DATA_LEN = CW'(BYTES);
  localparam logic [CW-1:0] REC_LEN  = CW'(BYTES + CSUM);

  logic [8*BYTES-1:0] r_shadow, w_shadow_base, w_shadow_nxt;
  logic [8*BYTES+7:0] w_shift;
  logic [7:0]         r_sum, w_sum_base, w_sum_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_base, w_cnt_nxt;
  logic               r_busy;

  // Next record state: restart clears first, then an accepted byte is applied on top
  always_comb begin
    w_shadow_base = i_restart ? '0 : r_shadow;
    w_sum_base    = i_restart ? 8'h00 : r_sum;
    w_cnt_base    = i_restart ? '0 : r_cnt;
    // Shifting through a wider vector keeps BYTES=1 legal (no zero-width slice)
    w_shift       = {i_din, w_shadow_base} >> 8;
    w_shadow_nxt  = w_shadow_base;
    w_sum_nxt     = w_sum_base;
    w_cnt_nxt     = w_cnt_base;
    o_extra       = 1'b0;
    if (i_edge) begin
      if (w_cnt_base < DATA_LEN) begin
        w_shadow_nxt = w_shift[8*BYTES-1:0];
        w_sum_nxt    = sum8(w_sum_base, i_din);
        w_cnt_nxt    = w_cnt_base + 1'b1;
      end else if (w_cnt_base < REC_LEN) begin
        w_sum_nxt    = sum8(w_sum_base, i_din);
        w_cnt_nxt    = w_cnt_base + 1'b1;
      end else begin
        o_extra      = 1'b1;
      end
    end
    o_done = i_edge && !o_extra && (w_cnt_nxt == REC_LEN);
  end

  // Record registers; busy is registered alongside the counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_sum    <= 8'h00;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      r_sum    <= w_sum_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= (w_cnt_nxt != '0) && (w_cnt_nxt != REC_LEN);
    end
  end

  assign o_shadow = r_shadow;
  assign o_sum    = r_sum;
  assign o_cnt    = r_cnt;
  assign o_busy   = r_busy;

endmodule

// File: rtl/jtcps2_cfgload.sv
// Byte-serial configuration loader. Bytes are taken on rising edges of din_we,
// collected in a shadow record and copied to cfg only once the full record
// (and its checksum, when enabled) has arrived, so consumers never see a
// partially loaded record.
module jtcps2_cfgload
  import jtcps2_pkg::*;
#(
  parameter  int BYTES = CPS2_KEY_BYTES,
  parameter  int CSUM  = 1,
  localparam int CW    = $clog2(BYTES + 2)
)(
  input  logic             clk,
  input  logic             rst,
  jtcps2_cfgload_if.slave  bus
);

  logic                r_last_we;
  logic                r_pend;
  logic [8*BYTES-1:0]  r_cfg;
  logic                r_valid;
  logic                r_err;
  logic                r_ovf;

  logic                w_edge;
  logic [8*BYTES-1:0]  w_shadow;
  logic [7:0]          w_sum;
  logic [CW-1:0]       w_cnt;
  logic                w_busy;
  logic                w_done;
  logic                w_extra;
  logic                w_sum_ok;

  // last_we resets low, so a strobe already high at reset release counts as an edge
  assign w_edge   = bus.din_we & ~r_last_we;
  assign w_sum_ok = (CSUM == 0) || (w_sum == 8'h00);

  jtcps2_cfgload_acc #(
    .BYTES (BYTES),
    .CSUM  (CSUM)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .i_restart (bus.restart),
    .i_edge    (w_edge),
    .i_din     (bus.din),
    .o_shadow  (w_shadow),
    .o_sum     (w_sum),
    .o_cnt     (w_cnt),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_extra   (w_extra)
  );

  // Strobe history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_last_we <= 1'b0;
    else     r_last_we <= bus.din_we;
  end

  // Commit one clock after the record completes; restart clears flags after the commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_cfg   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend <= w_done;
      if (r_pend) begin
        if (w_sum_ok) begin
          r_cfg   <= w_shadow;
          r_valid <= 1'b1;
          r_err   <= 1'b0;
        end else begin
          r_err   <= 1'b1;
        end
      end
      if (w_extra) r_ovf <= 1'b1;
      if (bus.restart) begin
        r_err <= 1'b0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.cfg   = r_cfg;
  assign bus.valid = r_valid;
  assign bus.busy  = w_busy;
  assign bus.err   = r_err;
  assign bus.ovf   = r_ovf;
  assign bus.cnt   = w_cnt;

endmodule

// File: tb/tb_jtcps2_cfgload.sv
// Scoreboard bench for two loader configurations driven by one download stream:
// A = 20 bytes + checksum, B = 4 bytes without checksum.
module tb_jtcps2_cfgload;
  import jtcps2_pkg::*;

  typedef struct packed {
    logic [159:0] cfg;
    logic         valid;
    logic         busy;
    logic         err;
    logic         ovf;
    logic [7:0]   cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic       din_we;
  logic [7:0] din;

  always #5 clk = ~clk;

  jtcps2_cfgload_if #(.BYTES(20)) bus_a();
  jtcps2_cfgload_if #(.BYTES(4))  bus_b();

  assign bus_a.restart = restart;
  assign bus_a.din     = din;
  assign bus_a.din_we  = din_we;
  assign bus_b.restart = restart;
  assign bus_b.din     = din;
  assign bus_b.din_we  = din_we;

  jtcps2_cfgload #(.BYTES(20), .CSUM(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  jtcps2_cfgload #(.BYTES(4),  .CSUM(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks   = 0;
  int failures = 0;

  // Reference model: list of bytes received in the current record per DUT
  logic [7:0]   rec   [2][64];
  int           n_rec [2];
  logic [159:0] m_cfg [2];
  bit           m_valid [2];
  bit           m_err   [2];
  bit           m_ovf   [2];
  bit           m_pend  [2];
  bit           m_last_we;

  exp_t qa[$];
  exp_t qb[$];

  function automatic int nbytes(input int d); return (d == 0) ? 20 : 4; endfunction
  function automatic int reclen(input int d); return (d == 0) ? 21 : 4; endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      n_rec[d] = 0; m_cfg[d] = '0; m_valid[d] = 0;
      m_err[d] = 0; m_ovf[d] = 0; m_pend[d] = 0;
    end
    m_last_we = 0;
  endtask

  task automatic model_dut(input int d, input bit rs, input bit edge_v, input logic [7:0] v);
    logic [7:0] s;
    if (m_pend[d]) begin
      s = 8'h00;
      for (int i = 0; i < reclen(d); i++) s = s + rec[d][i];
      if (d == 1 || s == 8'h00) begin
        m_cfg[d] = '0;
        for (int i = 0; i < nbytes(d); i++) m_cfg[d][8*i +: 8] = rec[d][i];
        m_valid[d] = 1;
        m_err[d]   = 0;
      end else begin
        m_err[d] = 1;
      end
    end
    m_pend[d] = 0;
    if (rs) begin
      n_rec[d] = 0; m_err[d] = 0; m_ovf[d] = 0;
    end
    if (edge_v) begin
      if (n_rec[d] < reclen(d)) begin
        rec[d][n_rec[d]] = v;
        n_rec[d]++;
        if (n_rec[d] == reclen(d)) m_pend[d] = 1;
      end else begin
        m_ovf[d] = 1;
      end
    end
  endtask

  function automatic exp_t model_out(input int d);
    exp_t e;
    e.cfg   = m_cfg[d];
    e.valid = m_valid[d];
    e.busy  = (n_rec[d] != 0) && (n_rec[d] != reclen(d));
    e.err   = m_err[d];
    e.ovf   = m_ovf[d];
    e.cnt   = 8'(n_rec[d]);
    return e;
  endfunction

  // One clock of stimulus: drive just after the negedge sample, predict, push after posedge
  task automatic step(input bit r, input bit rs, input bit we, input logic [7:0] v);
    bit   edge_v;
    exp_t ea, eb;
    @(negedge clk);
    #1;
    rst = r; restart = rs; din_we = we; din = v;
    if (r) begin
      model_reset();
    end else begin
      edge_v    = we && !m_last_we;
      m_last_we = we;
      model_dut(0, rs, edge_v, v);
      model_dut(1, rs, edge_v, v);
    end
    ea = model_out(0);
    eb = model_out(1);
    @(posedge clk);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic send(input logic [7:0] v, input bit rs, input int hold, input int gap);
    step(0, rs, 1, v);
    repeat (hold - 1) step(0, 0, 1, v);
    repeat (gap) step(0, 0, 0, v);
  endtask

  task automatic pulse_restart();
    step(0, 1, 0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 8'h00);
  endtask

  // Sends a 20-byte record and its checksum byte; good=0 corrupts the checksum
  task automatic send_record(input bit incr, input bit good);
    logic [7:0] s, v;
    s = 8'h00;
    for (int i = 0; i < 20; i++) begin
      v = incr ? 8'(i + 1) : 8'($urandom_range(0, 255));
      s = s + v;
      send(v, 0, $urandom_range(1, 3), $urandom_range(1, 3));
    end
    v = 8'h00 - s;
    if (!good) v = v + 8'h01;
    send(v, 0, 1, 2);
  endtask

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // Monitor: compare every registered output against the queued prediction
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_cfg",   bus_a.cfg,          e.cfg);
      chk("a_valid", 160'(bus_a.valid),  160'(e.valid));
      chk("a_busy",  160'(bus_a.busy),   160'(e.busy));
      chk("a_err",   160'(bus_a.err),    160'(e.err));
      chk("a_ovf",   160'(bus_a.ovf),    160'(e.ovf));
      chk("a_cnt",   160'(bus_a.cnt),    160'(e.cnt));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_cfg",   160'(bus_b.cfg),    e.cfg);
      chk("b_valid", 160'(bus_b.valid),  160'(e.valid));
      chk("b_busy",  160'(bus_b.busy),   160'(e.busy));
      chk("b_err",   160'(bus_b.err),    160'(e.err));
      chk("b_ovf",   160'(bus_b.ovf),    160'(e.ovf));
      chk("b_cnt",   160'(bus_b.cnt),    160'(e.cnt));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; restart = 1'b0; din_we = 1'b1; din = 8'h01;
    model_reset();

    // Strobe high through reset release: one byte on the first clock, then only edges count
    repeat (3) step(1, 0, 1, 8'h01);
    repeat (50) step(0, 0, 1, 8'h01);
    step(0, 0, 0, 8'h00);
    repeat (50) step(0, 0, 1, 8'h02);
    step(0, 0, 0, 8'h00);

    // Fresh reset, bad checksum first (nothing committed), then a good record
    repeat (2) step(1, 0, 0, 8'h00);
    send_record(1, 0);
    idle(2);
    pulse_restart();
    send_record(1, 1);
    idle(2);

    // Restart plus 10 bytes: partial record, cfg untouched
    pulse_restart();
    for (int i = 0; i < 10; i++) send(8'($urandom_range(0, 255)), 0, 1, 2);
    idle(2);

    // Restart and full random record, then 3 extra bytes, then restart clears ovf
    pulse_restart();
    send_record(0, 1);
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 0, 2, 2);
    pulse_restart();
    idle(2);

    // Restart coincident with the first edge, then AA BB CC DD
    send(8'hAA, 1, 1, 2);
    send(8'hBB, 0, 1, 2);
    send(8'hCC, 0, 1, 2);
    send(8'hDD, 0, 1, 3);

    // Restart on the commit clock still commits
    pulse_restart();
    for (int i = 0; i < 20; i++) send(8'(i * 7), 0, 1, 1);
    step(0, 0, 1, 8'h00 - 8'(7 * 190));
    pulse_restart();
    idle(3);

    // Randomized mix of records, partial loads, overflows and restarts
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin pulse_restart(); send_record(0, 1); end
        1: begin pulse_restart(); send_record(0, 0); end
        2: begin
             send(8'($urandom_range(0, 255)), 1, 1, 1);
             for (int i = 0; i < int'($urandom_range(0, 25)); i++)
               send(8'($urandom_range(0, 255)), 0, $urandom_range(1, 4), $urandom_range(1, 3));
           end
        3: begin
             for (int i = 0; i < int'($urandom_range(1, 6)); i++)
               send(8'($urandom_range(0, 255)), 0, 1, $urandom_range(1, 2));
             if ($urandom_range(0, 1) == 1) pulse_restart();
           end
        default: idle($urandom_range(1, 5));
      endcase
    end

    idle(3);
    @(negedge clk);
    #2;
    chk("queue_drained", 160'(qa.size() + qb.size()), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
